dot_product_accumulator: RTL and testbench
==========================================

# dot_product_accumulator

Downstream stage of the 32x32 pipelined multiplier in the matrix multiplier datapath. It consumes the 64-bit unsigned product stream with its valid strobe and sums every LEN consecutive products into one dot-product result, i.e. one output matrix element. Completed sums are queued in a small output FIFO with a valid/ready handshake toward the result writer. The multiplier cannot be stalled, so FIFO overflow drops the sum and sets a sticky error flag.

## Interface
- PROD_W, 64, product width; must match the multiplier output.
- ACC_W, 72, accumulator and sum width; ACC_W >= PROD_W.
- LEN, 4, products per dot product; LEN >= 1.
- FIFO_DEPTH, 2, output FIFO entries; power of two, >= 2.
- clk  in  1  clock; all logic on posedge clk.
- reset  in  1  reset, synchronous, active-high.
- prod_in  in  PROD_W  unsigned product from the multiplier.
- prod_valid  in  1  prod_in is a new term this cycle.
- clear  in  1  discard the partial sum and restart the term count.
- sum_out  out  ACC_W  head-of-FIFO dot-product result.
- sum_valid  out  1  FIFO not empty.
- sum_ready  in  1  consumer accepts sum_out this cycle.
- term_idx  out  $clog2(LEN)  (1 bit when LEN=1)  index of the next expected term, 0..LEN-1.
- overflow  out  1  sticky; a completed sum was dropped.
- sat  out  1  sticky; a saturation occurred (only when ACC_SATURATE_EN is defined; tied 0 otherwise).

## Operation
- Reset: acc=0, term_idx=0, FIFO empty, sum_valid=0, sum_out=0, overflow=0, sat=0.
- Term accept: prod_valid=1 and clear=0. If term_idx==0, acc <= zero-extended prod_in. Otherwise acc <= acc + prod_in. term_idx increments.
- Completion: a term accepted at term_idx==LEN-1 makes next_sum = acc + prod_in (prod_in alone when LEN=1). next_sum is pushed to the FIFO and term_idx wraps to 0. acc is not reloaded from the FIFO.
- Push rule: a push succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the sum is discarded and overflow <= 1. overflow is cleared only by reset.
- Pop: sum_valid & sum_ready pops the head entry. sum_out shows the new head, or 0 when the FIFO is empty.
- Simultaneous push and pop on an empty FIFO: the pop is impossible (sum_valid=0). The push lands and sum_valid rises next cycle.
- clear: acc <= 0 and term_idx <= 0. clear takes priority over a same-cycle prod_valid, and that product is discarded. clear has no effect on FIFO contents, overflow, or sat.
- Arithmetic: unsigned. Without saturation, the sum wraps modulo 2^ACC_W.
- reset mid-accumulation or with a non-empty FIFO: all state is lost and the outputs return to their reset values on the next edge.

## Timing
- Terms are accepted every cycle with no bubbles required.
- Latency: the last term is sampled at edge k, and sum_valid=1 with the correct sum_out is visible after edge k (one cycle).
- Throughput: one sum per LEN cycles sustained, including LEN=1 at one sum per cycle.
- Back-to-back dot products need no gap. A term at term_idx==0 in the cycle after a completion starts a fresh sum.
- All outputs are registered, with no combinational path from the inputs to the outputs.

## Configuration
- ACC_SATURATE_EN defined: each add clamps at 2^ACC_W-1 when the carry out of bit ACC_W-1 is set. The clamped value propagates through the rest of the sum, and sat <= 1 (sticky until reset).
- ACC_SATURATE_EN undefined: additions wrap and sat is constant 0.

## Test plan
- Basic sum, LEN=4, sum_ready=1: products 1,2,3,4 on consecutive cycles -> one cycle after the 4th, sum_valid=1 and sum_out=10 for one cycle; term_idx reads 0.
- Max operands: four terms of 0xFFFF_FFFF_FFFF_FFFF -> sum_out = 0x3_FFFF_FFFF_FFFF_FFFC (ACC_W=72). With ACC_W=64 and the macro defined: sum_out = 0xFFFF_FFFF_FFFF_FFFF and sat=1. With ACC_W=64 and the macro undefined: sum_out = 0xFFFF_FFFF_FFFF_FFFC and sat=0.
- Backpressure: sum_ready=0, three complete dot products 1+1+1+1, 2+2+2+2, 3+3+3+3 -> FIFO holds 4 and 8, and overflow=1 after the third completes. Then raise sum_ready -> pops 4 then 8, and sum_valid falls.
- Full FIFO with pop on the completion cycle: the third sum completes while sum_ready=1 -> no drop, overflow stays 0, outputs in order 4, 8, 12.
- clear mid-vector: terms 5,5, then clear together with a valid term 9, then 1,1,1,1 -> sum_out=4 (the 9 is discarded).
- Reset mid-vector with a non-empty FIFO: sum_valid=0 and term_idx=0 next cycle. Then terms 7,0,0,0 -> sum_out=7.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums every LEN products into one dot-product result; define ACC_SATURATE_EN to clamp instead of wrap.
// Latency: sum visible one cycle after its last term is sampled; all outputs registered.
// Backpressure: output FIFO with valid/ready; input cannot stall, so a push to a full FIFO drops the sum and sets overflow.
module dot_product_accumulator #(
    parameter int PROD_W     = 64,
    parameter int ACC_W      = 72,
    parameter int LEN        = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int IDX_W     = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              clear,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [IDX_W-1:0]  term_idx,
    output logic              overflow,
    output logic              sat
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] mem_q [FIFO_DEPTH];
    logic [ACC_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_out_q, sum_out_d;
    logic             sum_valid_q, sum_valid_d;
    logic             ovf_q, ovf_d;

    logic             accept, complete, pop, full, push_ok;
    logic [ACC_W-1:0] addend, prod_ext, next_sum;

    assign accept   = prod_valid & ~clear;
    assign complete = accept & (idx_q == LAST_IDX);
    assign addend   = (idx_q == '0) ? '0 : acc_q;
    assign prod_ext = ACC_W'(prod_in);

`ifdef ACC_SATURATE_EN
    logic [ACC_W:0] add_full;
    logic           sat_q;

    assign add_full = {1'b0, addend} + {1'b0, prod_ext};
    assign next_sum = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            sat_q <= 1'b0;
        else if (accept && add_full[ACC_W])
            sat_q <= 1'b1;
    end
    assign sat = sat_q;
`else
    assign next_sum = addend + prod_ext;
    assign sat      = 1'b0;
`endif

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop     = sum_valid_q & sum_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_ok = complete & (~full | pop);

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        ovf_d = ovf_q;
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;

        if (clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (accept) begin
            acc_d = next_sum;
            idx_d = complete ? '0 : idx_q + IDX_W'(1);
        end

        if (pop)
            rd_d = rd_q + PTR_W'(1);

        if (push_ok) begin
            mem_d[wr_q] = next_sum;
            wr_d        = wr_q + PTR_W'(1);
        end else if (complete) begin
            ovf_d = 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Register the post-update head so sum_out never depends combinationally on inputs.
        sum_valid_d = (cnt_d != '0);
        sum_out_d   = sum_valid_d ? mem_d[rd_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;
    assign term_idx  = idx_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: reference model pushes expected sums into a queue, tasks pop and compare.
module tb_dot_product_accumulator;

    localparam int PROD_W     = 64;
    localparam int ACC_W      = 72;
    localparam int LEN        = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int IDX_W      = 2;

    logic              clk;
    logic              reset;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              clear;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic [IDX_W-1:0]  term_idx;
    logic              overflow;
    logic              sat;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] m_acc;
    int               m_idx;
    logic [ACC_W-1:0] exp_v;

    dot_product_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
        .clear(clear), .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .term_idx(term_idx), .overflow(overflow), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of stimulus, update the model, advance to #1 after the edge.
    task automatic drive(input logic v, input logic c, input logic [PROD_W-1:0] p);
        logic [ACC_W-1:0] ns;
        prod_valid = v;
        clear      = c;
        prod_in    = p;
        if (c) begin
            m_acc = '0;
            m_idx = 0;
        end else if (v) begin
            ns    = ((m_idx == 0) ? {ACC_W{1'b0}} : m_acc) + {{(ACC_W-PROD_W){1'b0}}, p};
            m_acc = ns;
            if (m_idx == LEN - 1) begin
                exp_q.push_back(ns);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_acc = '0;
        m_idx = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; prod_valid = 1'b0; clear = 1'b0; prod_in = '0; sum_ready = 1'b0;
        m_acc = '0; m_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid: got %b required 0", sum_valid); end
        n_checks++; if (sum_out !== '0) begin n_fail++; $display("FAIL reset_sum_out: got %h required 0", sum_out); end
        n_checks++; if (term_idx !== '0) begin n_fail++; $display("FAIL reset_term_idx: got %0d required 0", term_idx); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b required 0", sat); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        sum_ready = 1'b1;
        drive(1'b1, 1'b0, 64'd1);
        drive(1'b1, 1'b0, 64'd2);
        drive(1'b1, 1'b0, 64'd3);
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", sum_valid); end
        drive(1'b1, 1'b0, 64'd4);
        n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b required 1", sum_valid); end
        exp_v = exp_q.pop_front();
        n_checks++; if (sum_out !== exp_v) begin n_fail++; $display("FAIL basic_sum: got %0d required %0d", sum_out, exp_v); end
        n_checks++; if (term_idx !== 2'd0) begin n_fail++; $display("FAIL basic_term_idx: got %0d required 0", term_idx); end
        drive(1'b0, 1'b0, 64'd0);
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b required 0", sum_valid); end
    endtask

    task automatic test_max();
        sum_ready = 1'b1;
        for (int i = 0; i < LEN; i++) drive(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_v = exp_q.pop_front();
        n_checks++; if (sum_out !== 72'h3_FFFF_FFFF_FFFF_FFFC || sum_valid !== 1'b1) begin
            n_fail++; $display("FAIL max_sum: got %h valid %b required 3fffffffffffffffc valid 1 (model %h)", sum_out, sum_valid, exp_v);
        end
        n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL max_sat: got %b required 0", sat); end
        drive(1'b0, 1'b0, 64'd0);
    endtask

    task automatic test_back_to_back();
        sum_ready = 1'b1;
        for (int i = 0; i < 4 * LEN; i++) begin
            drive(1'b1, 1'b0, {$urandom, $urandom});
            if (sum_valid) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (sum_out !== exp_v) begin n_fail++; $display("FAIL b2b_sum: got %h required %h", sum_out, exp_v); end
            end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending sums required 0", exp_q.size()); end
        exp_q.delete();
        drive(1'b0, 1'b0, 64'd0);
    endtask

    task automatic test_clear();
        sum_ready = 1'b1;
        drive(1'b1, 1'b0, 64'd5);
        drive(1'b1, 1'b0, 64'd5);
        n_checks++; if (term_idx !== IDX_W'(m_idx)) begin n_fail++; $display("FAIL clear_idx_pre: got %0d required %0d", term_idx, m_idx); end
        drive(1'b1, 1'b1, 64'd9);
        n_checks++; if (term_idx !== 2'd0) begin n_fail++; $display("FAIL clear_idx: got %0d required 0", term_idx); end
        for (int i = 0; i < LEN; i++) drive(1'b1, 1'b0, 64'd1);
        n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL clear_valid: got %b required 1", sum_valid); end
        exp_v = exp_q.pop_front();
        n_checks++; if (sum_out !== exp_v || exp_v !== 72'd4) begin n_fail++; $display("FAIL clear_sum: got %0d required 4", sum_out); end
        drive(1'b0, 1'b0, 64'd0);
    endtask

    task automatic test_backpressure();
        sum_ready = 1'b0;
        for (int s = 1; s <= 3; s++)
            for (int i = 0; i < LEN; i++) drive(1'b1, 1'b0, PROD_W'(s));
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b required 1", overflow); end
        n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", sum_valid); end
        void'(exp_q.pop_back());
        sum_ready = 1'b1;
        for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
            if (sum_valid) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (sum_out !== exp_v) begin n_fail++; $display("FAIL bp_order: got %0d required %0d", sum_out, exp_v); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending sums required 0", exp_q.size()); end
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b required 0", sum_valid); end
    endtask

    task automatic test_full_pop();
        do_reset();
        sum_ready = 1'b0;
        for (int s = 1; s <= 2; s++)
            for (int i = 0; i < LEN; i++) drive(1'b1, 1'b0, PROD_W'(s));
        for (int i = 0; i < LEN - 1; i++) drive(1'b1, 1'b0, 64'd3);
        sum_ready = 1'b1;
        exp_v = exp_q.pop_front();
        n_checks++; if (sum_valid !== 1'b1 || sum_out !== exp_v) begin n_fail++; $display("FAIL fp_head: got %0d valid %b required %0d valid 1", sum_out, sum_valid, exp_v); end
        drive(1'b1, 1'b0, 64'd3);
        for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
            if (sum_valid) begin
                exp_v = exp_q.pop_front();
                n_checks++; if (sum_out !== exp_v) begin n_fail++; $display("FAIL fp_order: got %0d required %0d", sum_out, exp_v); end
            end
            @(posedge clk); #1;
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fp_drain: got %0d pending sums required 0", exp_q.size()); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_overflow: got %b required 0", overflow); end
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty: got %b required 0", sum_valid); end
    endtask

    task automatic test_reset_mid();
        sum_ready = 1'b0;
        for (int i = 0; i < LEN; i++) drive(1'b1, 1'b0, 64'd1);
        drive(1'b1, 1'b0, 64'd2);
        drive(1'b1, 1'b0, 64'd2);
        n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b required 1", sum_valid); end
        do_reset();
        n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b required 0", sum_valid); end
        n_checks++; if (term_idx !== 2'd0) begin n_fail++; $display("FAIL rm_term_idx: got %0d required 0", term_idx); end
        n_checks++; if (sum_out !== '0) begin n_fail++; $display("FAIL rm_sum_out: got %h required 0", sum_out); end
        sum_ready = 1'b1;
        drive(1'b1, 1'b0, 64'd7);
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b1, 1'b0, 64'd0);
        exp_v = exp_q.pop_front();
        n_checks++; if (sum_valid !== 1'b1 || sum_out !== exp_v || exp_v !== 72'd7) begin
            n_fail++; $display("FAIL rm_sum: got %0d valid %b required 7 valid 1", sum_out, sum_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_clear();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
